fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the MIPS core. Holds the program counter, drives the address input of `instruction_memory` (`sel`), and captures the returned word into the IF/ID pipeline register for the decoder. It resolves `J` instructions in fetch and accepts taken-branch redirects and stalls from later stages.

## Interface
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `OP_J`, default 6'b000001: opcode of the jump instruction, matching the core's encoding.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `imem_addr`  out  32: fetch address, connected to `instruction_memory.sel`; equal to `pc`, combinational.
- `imem_data`  in  32: instruction word returned combinationally by `instruction_memory.out`.
- `stall`  in  1: hold request from decode/hazard logic.
- `redirect`  in  1: taken branch from execute.
- `redirect_pc`  in  32: branch target; bits [1:0] are ignored.
- `if_valid`  out  1: IF/ID register holds a real instruction.
- `if_instr`  out  32: IF/ID instruction word.
- `if_pc`  out  32: address of `if_instr`.
- `if_pc4`  out  32: `if_pc + 4`, used for branch-target arithmetic.
- `fetch_count`  out  32: number of instructions delivered with `if_valid=1`.

## Operation
- Registers: `pc` [31:0]; IF/ID register (`if_valid`, `if_instr`, `if_pc`, `if_pc4`); `fetch_count`.
- `pc_plus4 = pc + 32'd4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- `is_j = (imem_data[31:26] == OP_J)`; `j_target = {pc_plus4[31:28], imem_data[25:0], 2'b00}`.
- Next-state selection, evaluated per edge in priority order:
  1. `redirect=1`, regardless of `stall`: `pc <= {redirect_pc[31:2], 2'b00}`. IF/ID is flushed: `if_valid<=0` and `if_instr<=0`. `if_pc`/`if_pc4` hold.
  2. `stall=1`: `pc` and the whole IF/ID register hold.
  3. `is_j=1`: `pc <= j_target`. The J is consumed in fetch and is not forwarded. IF/ID loads a bubble: `if_valid<=0`, `if_instr<=0`, `if_pc<=pc`, `if_pc4<=pc_plus4`.
  4. Otherwise: `pc <= pc_plus4`; `if_valid<=1`, `if_instr<=imem_data`, `if_pc<=pc`, `if_pc4<=pc_plus4`.
- `fetch_count` increments by 1 only on case 4 edges and wraps at 2^32.
- The PC is always word-aligned, so `instruction_memory` never sees a misaligned `sel`. A zero word (`default`/sll-nop) is forwarded as a valid instruction.
- A `J` whose target is its own address loops forever, producing only bubbles. This is legal.

## Timing
- Reset (async assert, `rst_n=0`): `pc=RESET_PC`, `if_valid=0`, `if_instr=0`, `if_pc=0`, `if_pc4=0`, `fetch_count=0`. Outputs take these values immediately, without waiting for a clock.
- First edge after `rst_n` rises delivers the instruction at `RESET_PC`.
- Reset deasserted mid-stall or mid-redirect: the edge after release behaves per the priority list. No partial state survives the reset.
- `imem_addr` changes only after a clock edge or reset. Same-cycle path: `pc` → `instruction_memory` → `imem_data` → `is_j` → `pc` D-input.
- Latency: 1 cycle from `pc` to the IF/ID outputs.
- Redirect penalty: 1 bubble (the flushed wrong-path fetch). The target appears in IF/ID 2 edges after `redirect` is sampled.
- J penalty: 1 bubble.
- Throughput: 1 instruction per cycle when there is no stall, redirect or J.
- `stall` held N cycles: the same `if_instr` is presented for N+1 cycles; `fetch_count` is unchanged during the stall.

## Test plan
- Reset/sequential: memory holds 0x20000003 @0 and 0x24210004 @4. Release reset. Required: `imem_addr`=0 → 4 → 8; `if_pc`=0 with `if_instr`=0x20000003, then `if_pc`=4; `if_valid`=1; `fetch_count`=1 → 2.
- Jump: word 0x04000000 at address 40. Required: on the edge that samples it, `pc`→0 and `if_valid=0`. The next edge delivers address 0 valid. `fetch_count` is not incremented for the J.
- Redirect: in the cycle `pc`=28, assert `redirect` with `redirect_pc`=16. Required: `pc`→16, `if_valid=0`, `if_instr`=0; the next edge gives `if_pc`=16.
- Redirect with misaligned target and simultaneous stall: `redirect_pc`=0x23, `stall`=1. Required: `pc`→0x20 (redirect wins over stall) and IF/ID is flushed.
- Stall: hold `stall` for 3 cycles at `pc`=8. Required: `pc`, `if_instr` and `fetch_count` are frozen for 3 edges, then advance to 12.
- Wrap and async reset: with `RESET_PC`=32'hFFFF_FFFC, the next `pc` is 0 and `if_pc4`=0. Then pull `rst_n` low between edges. Required: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the MIPS core.
// Holds the PC, presents it to instruction_memory, and captures the returned
// word into the IF/ID register. J instructions are resolved here. Taken
// branches from execute redirect the PC, and stalls from decode hold it.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   imem_addr           fetch address to instruction_memory.sel (= pc)
//   imem_data           instruction word from instruction_memory.out
//   stall               hold request from decode/hazard logic
//   redirect            taken-branch redirect from execute
//   redirect_pc         branch target (bits [1:0] ignored)
//   if_valid/if_instr   IF/ID register: valid flag and instruction word
//   if_pc/if_pc4        IF/ID register: instruction address and address + 4
//   fetch_count         count of instructions delivered with if_valid = 1
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [5:0]  OP_J     = 6'b000001
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] fetch_count
);

   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] r_pc;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_instr;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_if_pc4;
   logic [XLEN-1:0] r_fetch_count;

   logic [XLEN-1:0] w_pc_plus4;
   logic            w_is_j;
   logic [XLEN-1:0] w_j_target;

   // Sequential PC and jump decode on the word currently being fetched
   assign w_pc_plus4 = r_pc + XLEN'(4);
   assign w_is_j     = (imem_data[31:26] == OP_J);
   assign w_j_target = {w_pc_plus4[31:28], imem_data[25:0], 2'b00};

   // PC, IF/ID register and delivered-instruction counter.
   // Priority: redirect > stall > J > sequential.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_instr    <= '0;
         r_if_pc       <= '0;
         r_if_pc4      <= '0;
         r_fetch_count <= '0;
      end else if (redirect) begin
         // Flush the wrong-path fetch; if_pc/if_pc4 keep their last values
         r_pc       <= {redirect_pc[31:2], 2'b00};
         r_if_valid <= 1'b0;
         r_if_instr <= '0;
      end else if (!stall) begin
         r_if_pc  <= r_pc;
         r_if_pc4 <= w_pc_plus4;
         if (w_is_j) begin
            // J is consumed here; a bubble goes down the pipe
            r_pc       <= w_j_target;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
         end else begin
            r_pc          <= w_pc_plus4;
            r_if_valid    <= 1'b1;
            r_if_instr    <= imem_data;
            r_fetch_count <= r_fetch_count + XLEN'(1);
         end
      end
   end

   assign imem_addr   = r_pc;
   assign if_valid    = r_if_valid;
   assign if_instr    = r_if_instr;
   assign if_pc       = r_if_pc;
   assign if_pc4      = r_if_pc4;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A small word-indexed memory
// model answers imem_addr combinationally. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_w_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;

   logic [31:0] imem_addr, imem_data, if_instr, if_pc, if_pc4, fetch_count;
   logic        if_valid;
   logic [31:0] w_imem_addr, w_imem_data, w_if_instr, w_if_pc, w_if_pc4, w_fetch_count;
   logic        w_if_valid;

   logic [31:0] mem [64];

   int vectors = 0;
   int miscompares = 0;

   logic [160:0] got_main, got_wrap, exp_v;

   always #5 clk = ~clk;

   assign imem_data   = mem[imem_addr[7:2]];
   assign w_imem_data = mem[w_imem_addr[7:2]];

   assign got_main = {imem_addr, if_valid, if_instr, if_pc, if_pc4, fetch_count};
   assign got_wrap = {w_imem_addr, w_if_valid, w_if_instr, w_if_pc, w_if_pc4, w_fetch_count};

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
      .fetch_count(fetch_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_w_n), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
      .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc4(w_if_pc4),
      .fetch_count(w_fetch_count)
   );

   // Advance one clock and sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset values held while rst_n is low, then release between edges
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      exp_v = {32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL reset got=%h exp=%h", got_main, exp_v);
      end
      rst_n = 1'b1;
   endtask

   // First edges after release deliver 0 then 4 back-to-back
   task automatic test_sequential();
      step();
      exp_v = {32'd4, 1'b1, 32'h2000_0003, 32'd0, 32'd4, 32'd1};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL seq_first got=%h exp=%h", got_main, exp_v);
      end
      step();
      exp_v = {32'd8, 1'b1, 32'h2421_0004, 32'd4, 32'd8, 32'd2};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL seq_second got=%h exp=%h", got_main, exp_v);
      end
   endtask

   // Stall for 3 edges at pc=8: everything frozen, then advance to 12
   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_v = {32'd8, 1'b1, 32'h2421_0004, 32'd4, 32'd8, 32'd2};
         vectors++;
         if (got_main !== exp_v) begin
            miscompares++;
            $display("FAIL stall_hold%0d got=%h exp=%h", i, got_main, exp_v);
         end
      end
      stall = 1'b0;
      step();
      exp_v = {32'd12, 1'b1, 32'h2400_0002, 32'd8, 32'd12, 32'd3};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL stall_release got=%h exp=%h", got_main, exp_v);
      end
   endtask

   // Redirect to 16 while pc=28: one flushed bubble, then the target
   task automatic test_redirect();
      repeat (4) step();
      exp_v = {32'd28, 1'b1, 32'h2400_0006, 32'd24, 32'd28, 32'd7};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL redir_pre got=%h exp=%h", got_main, exp_v);
      end
      redirect    = 1'b1;
      redirect_pc = 32'd16;
      step();
      redirect = 1'b0;
      exp_v = {32'd16, 1'b0, 32'd0, 32'd24, 32'd28, 32'd7};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL redir_flush got=%h exp=%h", got_main, exp_v);
      end
      step();
      exp_v = {32'd20, 1'b1, 32'h2400_0004, 32'd16, 32'd20, 32'd8};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL redir_target got=%h exp=%h", got_main, exp_v);
      end
   endtask

   // Misaligned redirect with simultaneous stall: redirect wins, aligned to 0x20
   task automatic test_redirect_stall();
      redirect    = 1'b1;
      redirect_pc = 32'h23;
      stall       = 1'b1;
      step();
      redirect = 1'b0;
      stall    = 1'b0;
      exp_v = {32'h20, 1'b0, 32'd0, 32'd16, 32'd20, 32'd8};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL redir_stall got=%h exp=%h", got_main, exp_v);
      end
      step();
      exp_v = {32'h24, 1'b1, 32'h2400_0008, 32'h20, 32'h24, 32'd9};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL redir_stall_next got=%h exp=%h", got_main, exp_v);
      end
   endtask

   // J at address 40 targets 0: bubble, no count, then address 0 delivered
   task automatic test_jump();
      step();
      exp_v = {32'd40, 1'b1, 32'h2400_0009, 32'h24, 32'h28, 32'd10};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL jump_pre got=%h exp=%h", got_main, exp_v);
      end
      step();
      exp_v = {32'd0, 1'b0, 32'd0, 32'd40, 32'd44, 32'd10};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL jump_bubble got=%h exp=%h", got_main, exp_v);
      end
      step();
      exp_v = {32'd4, 1'b1, 32'h2000_0003, 32'd0, 32'd4, 32'd11};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL jump_target got=%h exp=%h", got_main, exp_v);
      end
   endtask

   // PC wraps from 0xFFFFFFFC to 0; then async reset between edges on both
   task automatic test_wrap_async_reset();
      exp_v = {32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
      vectors++;
      if (got_wrap !== exp_v) begin
         miscompares++;
         $display("FAIL wrap_reset got=%h exp=%h", got_wrap, exp_v);
      end
      rst_w_n = 1'b1;
      step();
      exp_v = {32'd0, 1'b1, 32'h2400_003F, 32'hFFFF_FFFC, 32'd0, 32'd1};
      vectors++;
      if (got_wrap !== exp_v) begin
         miscompares++;
         $display("FAIL wrap_pc got=%h exp=%h", got_wrap, exp_v);
      end
      #2;
      rst_n   = 1'b0;
      rst_w_n = 1'b0;
      #1;
      exp_v = {32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
      vectors++;
      if (got_wrap !== exp_v) begin
         miscompares++;
         $display("FAIL wrap_async_rst got=%h exp=%h", got_wrap, exp_v);
      end
      exp_v = {32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
      vectors++;
      if (got_main !== exp_v) begin
         miscompares++;
         $display("FAIL main_async_rst got=%h exp=%h", got_main, exp_v);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
      mem[0]  = 32'h2000_0003;
      mem[1]  = 32'h2421_0004;
      mem[10] = 32'h0400_0000;

      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_jump();
      test_wrap_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
